// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the DFF bank arbiter: FSM encoding and default sizing.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_HOLD_CYC = 2;

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning from ptr upward with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any
);

    int idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that loads one requester's data into a shared W-bit register,
// then waits HOLD_CYC cycles before arbitrating again.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic [$clog2(N)-1:0] q_owner,
    output logic                 q_valid,
    output logic                 busy
);

    localparam int PW = $clog2(N);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [3:0]    cnt;
    logic [PW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_idx),
        .any    (pick_any)
    );

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the bank itself is reset too, so an aborted write leaves q at zero, not stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            q       <= '0;
            q_owner <= '0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        win   <= pick_idx;
                        gnt   <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // din is taken here whether or not req is still held
                    q       <= din[int'(win)*W +: W];
                    q_owner <= win;
                    q_valid <= 1'b1;
                    gnt     <= '0;
                    ptr     <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
                    if (HOLD_CYC == 0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= 4'(HOLD_CYC);
                        state <= COOL;
                    end
                end
                COOL: begin
                    if (cnt <= 4'd1) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench: an edge-counting reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dff_bank_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HOLD = 2;
    localparam int PW   = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [PW-1:0]  q_owner;
    logic           q_valid;
    logic           busy;

    int checks = 0;
    int errors = 0;

    dff_bank_arbiter #(.N(N), .W(W), .HOLD_CYC(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .q_valid (q_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Reference model: arbitration allowed once the edge count reaches next_arb.
    int          m_edge, m_ptr, m_pend, m_next_arb, m_owner;
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_q;
    logic         m_valid, m_busy;

    always @(posedge clk or posedge rst) begin
        int w;
        if (rst) begin
            m_edge <= 0; m_ptr <= 0; m_pend <= -1; m_next_arb <= 0; m_owner <= 0;
            m_gnt <= '0; m_q <= '0; m_valid <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            if (m_pend >= 0) begin
                m_q        <= din[m_pend*W +: W];
                m_owner    <= m_pend;
                m_valid    <= 1'b1;
                m_ptr      <= (m_pend + 1) % N;
                m_gnt      <= '0;
                m_pend     <= -1;
                m_next_arb <= m_edge + 1 + HOLD;
                m_busy     <= (HOLD > 0);
            end else if (m_edge >= m_next_arb) begin
                w = pick(req, m_ptr);
                if (w >= 0) begin
                    m_gnt  <= N'(1) << w;
                    m_pend <= w;
                    m_busy <= 1'b1;
                end else begin
                    m_busy <= 1'b0;
                end
            end else begin
                m_busy <= (m_edge + 1 < m_next_arb);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("gnt", 32'(gnt), 32'(m_gnt));
            check("q", 32'(q), 32'(m_q));
            check("q_owner", 32'(q_owner), 32'(m_owner));
            check("q_valid", 32'(q_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_busy));
        end
    end

    // Grant log: index and cycle of each grant, and q value written after it.
    int gq[$];
    int gcyc[$];
    int qq[$];
    int cyc = 0;
    logic prev_g = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_g) qq.push_back(int'(q));
            for (int i = 0; i < N; i++)
                if (gnt[i]) begin
                    gq.push_back(i);
                    gcyc.push_back(cyc);
                end
            prev_g <= |gnt;
        end else begin
            prev_g <= 1'b0;
        end
    end

    // Requesters drop their bit once they have seen their grant.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (gnt[i]) req[i] = 1'b0;
        end
    endtask

    task automatic set_din(input int i, input logic [W-1:0] v);
        din[i*W +: W] = v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_q", 32'(q), 0);
        check("rst_gnt", 32'(gnt), 0);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int base;
        req = '0;
        din = '0;
        rst = 1'b1;
        #2;
        check("init_q", 32'(q), 0);
        check("init_valid", 32'(q_valid), 0);
        check("init_gnt", 32'(gnt), 0);
        check("init_busy", 32'(busy), 0);
        #19 rst = 1'b0;
        @(negedge clk);
        #1;
        tick(5);
        check("idle_q", 32'(q), 0);
        check("idle_busy", 32'(busy), 0);

        // Single request from requester 1.
        set_din(1, 8'hA5);
        req = 4'b0010;
        tick(1);
        check("single_gnt", 32'(gnt), 32'h2);
        tick(1);
        check("single_q", 32'(q), 32'hA5);
        check("single_owner", 32'(q_owner), 1);
        check("single_valid", 32'(q_valid), 1);
        check("single_busy_cool", 32'(busy), 1);
        tick(2);
        check("single_busy_done", 32'(busy), 0);

        // All four request together from a fresh pointer.
        pulse_reset();
        for (int i = 0; i < N; i++) set_din(i, 8'(8'h10 + i));
        base = gq.size();
        req = 4'b1111;
        tick(18);
        check("simul_count", 32'(gq.size() - base), 4);
        for (int k = 0; k < 4; k++) begin
            if (gq.size() > base + k) begin
                check("simul_order", 32'(gq[base+k]), 32'(k));
                check("simul_q", 32'(qq[base+k]), 32'(8'h10 + k));
                if (k > 0) check("simul_spacing", 32'(gcyc[base+k] - gcyc[base+k-1]), 2 + HOLD);
            end
        end

        // Wrap-around: grant 2 leaves ptr at 3, so 0 wins over 2.
        base = gq.size();
        req = 4'b0100;
        tick(4);
        req = 4'b0101;
        tick(8);
        check("wrap_count", 32'(gq.size() - base), 3);
        if (gq.size() >= base + 3) begin
            check("wrap_first", 32'(gq[base+1]), 0);
            check("wrap_second", 32'(gq[base+2]), 2);
        end

        // Request withdrawn during GRANT still writes; request in COOL waits.
        set_din(3, 8'h3C);
        req = 4'b1000;
        tick(1);
        check("wd_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        tick(1);
        check("wd_q", 32'(q), 32'h3C);
        check("wd_owner", 32'(q_owner), 3);
        req = 4'b0001;
        tick(1);
        check("cool_gnt_a", 32'(gnt), 0);
        tick(1);
        check("cool_gnt_b", 32'(gnt), 0);
        tick(1);
        check("cool_late_gnt", 32'(gnt), 32'h1);
        tick(3);

        // Reset in the middle of COOL.
        set_din(2, 8'h77);
        req = 4'b0100;
        tick(1);
        check("mid_gnt", 32'(gnt), 32'h4);
        tick(1);
        check("mid_q", 32'(q), 32'h77);
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_q", 32'(q), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(q_valid), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        req = 4'b0001;
        tick(1);
        check("post_rst_gnt", 32'(gnt), 32'h1);
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
